voice_mixer: RTL

Sums the signed sample outputs of all oscillator voices once per audio sample, applies master volume, saturates to the DAC word width, and presents one registered sample to `dac_transmitter`. Sits between the oscillator bank (`N_OSCILLATORS` voices) and the DAC transmitter. Accumulation is sequential, one voice per `clk` cycle, so a single adder and multiplier serve all voices.

---
 rtl/voice_mixer_if.sv | 25 ++
 rtl/voice_mixer.sv | 116 +++++++++++
 2 files changed

// File: rtl/voice_mixer_if.sv
// Voice-mixer bus: mix request with voice snapshot inputs and mixed-sample results.
interface voice_mixer_if #(
   parameter int unsigned WIDTH    = 24,
   parameter int unsigned N_VOICES = 16
);
   logic                         sample_tick;
   logic [N_VOICES*WIDTH-1:0]    voices;
   logic [N_VOICES-1:0]          voice_en;
   logic [7:0]                   volume;
   logic signed [WIDTH-1:0]      out;
   logic                         out_valid;
   logic                         busy;
   logic                         clip;
   logic                         overrun;

   modport master (
      output sample_tick, voices, voice_en, volume,
      input  out, out_valid, busy, clip, overrun
   );

   modport slave (
      input  sample_tick, voices, voice_en, volume,
      output out, out_valid, busy, clip, overrun
   );
endinterface

// File: rtl/voice_mixer.sv
// Sequential voice mixer: one voice accumulated per cycle, master gain, saturation to
// the DAC word width, one registered sample per mix.
module voice_mixer #(
   parameter int unsigned WIDTH    = 24,
   parameter int unsigned N_VOICES = 16
) (
   input  logic          clk,
   input  logic          rstn,
   voice_mixer_if.slave  bus
);
   localparam int unsigned IDX_W  = $clog2(N_VOICES);
   localparam int unsigned ACC_W  = WIDTH + IDX_W;
   localparam int unsigned PROD_W = ACC_W + 9;

   // Saturation bounds sign-extended to the product width
   localparam logic signed [PROD_W-1:0] SAT_MAX =
      {{(PROD_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
   localparam logic signed [PROD_W-1:0] SAT_MIN =
      {{(PROD_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, ACCUM, SCALE, OUT} state_t;

   state_t                   state_q, state_d;
   logic signed [WIDTH-1:0]  snap_q [N_VOICES];
   logic [N_VOICES-1:0]      en_q;
   logic [7:0]               vol_q;
   logic signed [ACC_W-1:0]  acc_q;
   logic [IDX_W-1:0]         idx_q;
   logic signed [PROD_W-1:0] scaled_q;
   logic signed [PROD_W-1:0] prod;
   logic signed [WIDTH-1:0]  out_q;
   logic                     out_valid_q;
   logic                     busy_q;
   logic                     clip_q;
   logic                     overrun_q;
   logic                     last_voice;
   logic                     sat_hi;
   logic                     sat_lo;

   assign last_voice = (idx_q == IDX_W'(N_VOICES - 1));
   assign prod       = PROD_W'(acc_q) * PROD_W'($signed({1'b0, vol_q}));
   assign sat_hi     = (scaled_q > SAT_MAX);
   assign sat_lo     = (scaled_q < SAT_MIN);

   // State register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (bus.sample_tick) state_d = ACCUM;
         ACCUM:   if (last_voice)      state_d = SCALE;
         SCALE:   state_d = OUT;
         OUT:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Snapshot, accumulate, scale and saturate datapath
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < int'(N_VOICES); i++) snap_q[i] <= '0;
         en_q        <= '0;
         vol_q       <= '0;
         acc_q       <= '0;
         idx_q       <= '0;
         scaled_q    <= '0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         clip_q      <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         out_valid_q <= 1'b0;
         // A tick is only honoured in IDLE; the OUT cycle still counts as busy
         if (bus.sample_tick && (state_q != IDLE)) overrun_q <= 1'b1;
         unique case (state_q)
            IDLE: begin
               if (bus.sample_tick) begin
                  for (int i = 0; i < int'(N_VOICES); i++)
                     snap_q[i] <= bus.voices[i*WIDTH +: WIDTH];
                  en_q   <= bus.voice_en;
                  vol_q  <= bus.volume;
                  acc_q  <= '0;
                  idx_q  <= '0;
                  busy_q <= 1'b1;
               end
            end
            ACCUM: begin
               if (en_q[idx_q]) acc_q <= acc_q + ACC_W'(snap_q[idx_q]);
               idx_q <= idx_q + IDX_W'(1);
            end
            SCALE: scaled_q <= prod >>> 7;
            OUT: begin
               if (sat_hi)      out_q <= SAT_MAX[WIDTH-1:0];
               else if (sat_lo) out_q <= SAT_MIN[WIDTH-1:0];
               else             out_q <= scaled_q[WIDTH-1:0];
               clip_q      <= sat_hi | sat_lo;
               out_valid_q <= 1'b1;
               busy_q      <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign bus.out       = out_q;
   assign bus.out_valid = out_valid_q;
   assign bus.busy      = busy_q;
   assign bus.clip      = clip_q;
   assign bus.overrun   = overrun_q;
endmodule
